// File: rtl/clock_pkg.sv
// Shared wall-clock helpers: ms-to-cycles and clog2 constant functions, plus the
// per-button repeat FSM state encoding.
package clock_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2,
        HOLD_NOREP  = 2'd3
    } repeat_state_e;

    function automatic int ms_to_cycles(input int clk_rate_hz, input int ms);
        return clk_rate_hz / 1000 * ms;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchronizer, debounce counter and the
// auto-repeat FSM producing registered press/release strobes.
module button_channel
    import clock_pkg::*;
#(
    parameter int D         = 20,
    parameter int R0        = 500,
    parameter int RP        = 100,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n_i,
    output logic held_o,
    output logic press_o,
    output logic release_o
);

    localparam int DCNT_W = max_int(1, clog2(D + 1));
    localparam int RCNT_W = max_int(1, clog2(max_int(R0, RP) + 1));
    localparam logic [DCNT_W-1:0] D_LAST  = DCNT_W'(D - 1);
    localparam logic [RCNT_W-1:0] R0_LAST = RCNT_W'(R0 - 1);
    localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(RP - 1);

    logic              sync1_q, sync2_q;
    logic              held_q, held_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RCNT_W-1:0] rcnt_q;
    logic              press_q, release_q;
    repeat_state_e     state_q;
    logic              pressed_s, rise, fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the synchronizer resets to 1 because 1 means released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            held_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= button_n_i;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign pressed_s = ~sync2_q;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        dcnt_d = '0;
        held_d = held_q;
        if (pressed_s != held_q) begin
            if (dcnt_q == D_LAST) held_d = ~held_q;
            else                  dcnt_d = dcnt_q + 1'b1;
        end
    end

    assign rise = held_d & ~held_q;
    assign fall = ~held_d & held_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RELEASED;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (rise) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                        if (REPEAT_EN) state_q <= HOLD_DELAY;
                        else           state_q <= HOLD_NOREP;
                    end
                end
                HOLD_DELAY: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        rcnt_q    <= '0;
                        state_q   <= RELEASED;
                    end else if (rcnt_q == R0_LAST) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                        state_q <= HOLD_REPEAT;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        rcnt_q    <= '0;
                        state_q   <= RELEASED;
                    end else if (rcnt_q == RP_LAST) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                HOLD_NOREP: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        rcnt_q    <= '0;
                        state_q   <= RELEASED;
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

    assign held_o    = held_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low board buttons into debounced levels and
// press/release strobes, with optional per-channel auto-repeat.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int                     CLK_RATE_HZ      = 100_000_000,
    parameter int                     NUM_BUTTONS      = 3,
    parameter int                     DEBOUNCE_MS      = 10,
    parameter int                     REPEAT_DELAY_MS  = 500,
    parameter int                     REPEAT_PERIOD_MS = 150,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_ENABLE    = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons_n_i,
    output logic [NUM_BUTTONS-1:0] held_o,
    output logic [NUM_BUTTONS-1:0] press_o,
    output logic [NUM_BUTTONS-1:0] release_o
);

    // Repeat timings are floored at one cycle so a zero-ms setting cannot wrap the compare.
    localparam int D  = max_int(1, ms_to_cycles(CLK_RATE_HZ, DEBOUNCE_MS));
    localparam int R0 = max_int(1, ms_to_cycles(CLK_RATE_HZ, REPEAT_DELAY_MS));
    localparam int RP = max_int(1, ms_to_cycles(CLK_RATE_HZ, REPEAT_PERIOD_MS));

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_channel
        button_channel #(
            .D         (D),
            .R0        (R0),
            .RP        (RP),
            .REPEAT_EN (REPEAT_ENABLE[g])
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .button_n_i (buttons_n_i[g]),
            .held_o     (held_o[g]),
            .press_o    (press_o[g]),
            .release_o  (release_o[g])
        );
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the wall clock. Conditions the raw, bouncy, active-low board push-buttons (mode/next, increment, reset request).
- Delivers clean single-cycle press/release strobes and debounced levels to `wall_clock`.
- Provides optional auto-repeat, so a held increment button steps the value continuously.
- Sits between the board pins and `wall_clock`; replaces the bare inverters at the top level.

Parameters:
- CLK_RATE_HZ, 100_000_000, system clock frequency.
- NUM_BUTTONS, 3, number of independent channels.
- DEBOUNCE_MS, 10, stability time; D = max(1, CLK_RATE_HZ/1000*DEBOUNCE_MS) cycles.
- REPEAT_DELAY_MS, 500, hold time before first repeat; R0 = CLK_RATE_HZ/1000*REPEAT_DELAY_MS cycles.
- REPEAT_PERIOD_MS, 150, interval between repeats; RP = CLK_RATE_HZ/1000*REPEAT_PERIOD_MS cycles.
- REPEAT_ENABLE, {NUM_BUTTONS{1'b0}}, per-channel auto-repeat enable mask.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- buttons_n  input  NUM_BUTTONS  raw asynchronous buttons, 0 = pressed.
- held  output  NUM_BUTTONS  debounced level, 1 = pressed.
- press  output  NUM_BUTTONS  one-cycle strobe on debounced press and on each auto-repeat.
- release  output  NUM_BUTTONS  one-cycle strobe on debounced release.

Interface decision: one clock (`clk`); reset (`reset_n`) is asynchronous and active-low.

Behaviour:
- Reset (`reset_n`=0): asynchronous clear.
  - Synchronizer flops go to 1 (released).
  - Debounce and repeat counters go to 0.
  - FSM goes to RELEASED.
  - held, press and release go to 0.
- Channels are fully independent; simultaneous events on different channels produce simultaneous strobes.
- Synchronizer: two flops per channel; `pressed_s = ~sync2`.
- Debounce counter:
  - Counts while `pressed_s != held`; clears whenever `pressed_s == held`.
  - When the counter is D-1 and the mismatch persists, `held` toggles on that edge and the counter clears.
  - Any glitch shorter than D synchronized cycles produces no output.
- Latency: raw edge settling before clk edge 1 changes `held` (and fires the strobe) on edge D+2.
- press/release: registered and asserted in exactly the cycle `held` changes 0→1 / 1→0; high for one cycle.
- Repeat FSM per channel (counter width $clog2(max(R0,RP)+1)):
  - RELEASED: on held 0→1, press=1. Go to HOLD_DELAY with counter=0 if the REPEAT_ENABLE bit is set, else to HOLD_NOREP.
  - HOLD_DELAY: counter increments each cycle. At R0-1, press=1, counter clears, go to HOLD_REPEAT.
  - HOLD_REPEAT: counter increments. At RP-1, press=1 and counter clears.
  - HOLD_NOREP: wait.
  - Any hold state, held 1→0: release=1, counter clears, go to RELEASED. A repeat strobe never coincides with a release strobe; release wins.
- Button held across reset deassertion: re-debounced as a fresh press, so press fires on edge D+2 after `reset_n` rises.
- A release bounce after an auto-repeat restarts nothing until `held` actually falls.

Decomposition:
- Shared package (`clock_pkg`): ms-to-cycles constant function and `clog2` helper, reused by `wall_clock` and `led_display_driver`. Also the repeat FSM state encoding.
- Sub-module `button_channel`: synchronizer, debounce counter and repeat FSM for one button, with parameters D, R0, RP and REPEAT_EN.
- `button_conditioner` generates NUM_BUTTONS instances and computes the cycle constants.

Test Plan (CLK_RATE_HZ=10_000, DEBOUNCE_MS=2 → D=20, REPEAT_DELAY_MS=50 → R0=500, REPEAT_PERIOD_MS=10 → RP=100, REPEAT_ENABLE=3'b001):
1. buttons_n[1] 1→0 cleanly at t=0 → press[1] single pulse at cycle 22; held[1]=1 from 22; no further strobes while held 800 cycles.
2. buttons_n[0] toggles every 5 cycles for 60 cycles, then stays 0 → no strobe during bouncing; exactly one press[0] 22 cycles after the last edge.
3. buttons_n[0] held 0 for 800 cycles → press[0] at 22, 522, 622, 722. Released at 800 → release[0] at 822; no press after.
4. buttons_n[2] low for 15 cycles only → held[2], press[2] and release[2] stay 0.
5. All three buttons pressed in the same cycle → press=3'b111 in one cycle (cycle 22).
6. buttons_n[0] held; reset_n pulsed low at cycle 300 for 3 cycles → all outputs 0 immediately (asynchronous). After release at cycle 303, press[0] at 325 and repeats resume at 825.
